sha3_app_seq: RTL and testbench
===============================

# sha3_app_seq

Single-requester sequencer that drives the SHA3 core's control pulses (`start`, `process`, `run`, `done`) from a request/stream interface. It forwards message beats into the core, waits for absorption, then streams the digest out as 64-bit words. When the requested output exceeds one rate block, it issues manual `run` pulses between blocks. It sits between an application port (KMAC app interface or a test harness) and the `sha3` instance, and removes all software control sequencing for fixed-length and XOF hashing.

## Interface
Parameters:
- StateW, 1600, Keccak state width; must equal the core's state width.
- LenW, 16, width of the requested digest length in 64-bit words.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i / req_ready_o  in/out  1  request handshake.
- req_strength_i  in  3  keccak strength: 0=L128, 1=L224, 2=L256, 3=L384, 4=L512; other values are illegal.
- req_len_i  in  LenW  digest length in 64-bit words; 0 is legal.
- msg_valid_i / msg_ready_o  in/out  1  upstream message handshake.
- msg_data_i  in  64  message word.
- msg_strb_i  in  8  byte strobe.
- msg_last_i  in  1  final beat of the message.
- sha3_msg_valid_o / sha3_msg_ready_i  out/in  1  message handshake to the core.
- sha3_msg_data_o  out  64  message word to the core.
- sha3_msg_strb_o  out  8  byte strobe to the core.
- sha3_strength_o  out  3  latched request strength.
- sha3_start_o, sha3_process_o, sha3_run_o, sha3_done_o  out  1  single-cycle control pulses to the core.
- sha3_absorbed_i, sha3_block_processed_i, sha3_state_valid_i  in  1  core status.
- sha3_state_i  in  StateW  core state, share 0.
- digest_valid_o / digest_ready_i  out/in  1  digest handshake.
- digest_data_o  out  64  digest word.
- digest_last_o  out  1  marks the final digest word.
- busy_o  out  1  high whenever the FSM is not in Idle.
- error_o  out  1  single-cycle error pulse.

## Operation
- Rate in words R (from latched strength): L128=21, L224=18, L256=17, L384=13, L512=9.
- Registers:
  - strength (3b), latched at request accept.
  - remaining (LenW), latched at request accept.
  - word index idx (5b).
- Idle:
  - req_ready_o=1.
  - On req_valid_i: latch strength and length, go to Start.
  - An illegal strength still yields req_ready_o=1, but the request is dropped, error_o pulses, and the FSM stays in Idle.
- Start: sha3_start_o=1 for one cycle, then go to Absorb.
- Absorb:
  - sha3_msg_* = msg_*; msg_ready_o = sha3_msg_ready_i.
  - On an accepted beat with msg_last_i=1, go to Process.
  - In every other state, msg_ready_o=0 and sha3_msg_valid_o=0.
- Process: sha3_process_o=1 for one cycle, then go to WaitAbs.
- WaitAbs:
  - If remaining=0, go to Done on sha3_absorbed_i.
  - Otherwise go to Squeeze on sha3_absorbed_i, with idx=0.
- Squeeze:
  - digest_valid_o = sha3_state_valid_i.
  - digest_data_o = sha3_state_i[64*idx +: 64].
  - digest_last_o = (remaining==1).
  - On each digest handshake: remaining-1, idx+1.
  - If remaining reaches 0, go to Done.
  - Else if idx+1==R, go to Run with idx=0.
- Run: sha3_run_o=1 for one cycle, then go to RunWait.
- RunWait: on sha3_block_processed_i, go to Squeeze.
- Done: sha3_done_o=1 for one cycle, then go to Idle.
- Error conditions (single-cycle pulse on error_o; FSM continues):
  - sha3_state_valid_i falls while in Squeeze with no handshake that cycle.
  - sha3_block_processed_i asserts in Squeeze.
- Illegal FSM encoding forces Idle and pulses error_o.

## Timing
- Reset values:
  - All outputs 0, except req_ready_o=1.
  - FSM=Idle; remaining=0, idx=0, strength=0.
- Request accepted in cycle T:
  - sha3_start_o high in T+1.
  - Message beats accepted from T+2.
- Last beat accepted in cycle A: sha3_process_o high in A+1.
- Digest data and valid are combinational from sha3_state_i, sha3_state_valid_i and registered idx; zero added latency.
- Under digest_ready_i=1, one word is sent per cycle while sha3_state_valid_i=1.
- Final handshake of block k in cycle B: sha3_run_o high in B+1.
- Final digest handshake in cycle F:
  - sha3_done_o high in F+1.
  - req_ready_o high in F+2.
- Back-to-back requests: the next request is accepted at the earliest in F+2.
- digest_valid_o and digest_data_o must stay stable while digest_ready_i=0; the core holds its state in Squeeze, which guarantees this.
- Reset asserted mid-operation: all state clears immediately and no further pulses are issued. The core shares the reset.

## Test plan
- SHA3-256, empty message (one beat, strb=0, last=1), len=4 -> start, then process, then 4 words. Byte 0 of word 0 is 0xa7, byte 1 is 0xff; last word ends with bytes ...0xf8434a; digest_last_o on word 3; done one cycle later.
- SHAKE128, len=25 -> words 0..20, then exactly one sha3_run_o, wait for block_processed, then words 21..24 (idx 0..3). run_o count = 1, done_o count = 1.
- len=0, SHA3-512, 3-beat message -> no digest_valid_o; done_o follows absorbed by 1 cycle.
- Random digest_ready_i and sha3_msg_ready_i backpressure, L384, len=30 -> data stable under stall; 2 run pulses; output matches the reference model.
- Illegal strength 5 -> error_o pulses once, no start_o, FSM remains in Idle; next legal request completes normally.
- rst_ni asserted in Squeeze after word 2 -> all outputs at reset values next edge; a fresh SHA3-224 request then completes correctly.

Source files
------------

// File: rtl/sha3_app_seq_if.sv
// Request, message, digest and core-control bundle around sha3_app_seq.
// slave is the sequencer side, master the application/core harness side.
interface sha3_app_seq_if #(
    parameter int StateW = 1600,
    parameter int LenW   = 16
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [2:0]        req_strength_i;
    logic [LenW-1:0]   req_len_i;

    logic              msg_valid_i;
    logic              msg_ready_o;
    logic [63:0]       msg_data_i;
    logic [7:0]        msg_strb_i;
    logic              msg_last_i;

    logic              sha3_msg_valid_o;
    logic              sha3_msg_ready_i;
    logic [63:0]       sha3_msg_data_o;
    logic [7:0]        sha3_msg_strb_o;
    logic [2:0]        sha3_strength_o;
    logic              sha3_start_o;
    logic              sha3_process_o;
    logic              sha3_run_o;
    logic              sha3_done_o;
    logic              sha3_absorbed_i;
    logic              sha3_block_processed_i;
    logic              sha3_state_valid_i;
    logic [StateW-1:0] sha3_state_i;

    logic              digest_valid_o;
    logic              digest_ready_i;
    logic [63:0]       digest_data_o;
    logic              digest_last_o;

    logic              busy_o;
    logic              error_o;

    modport slave (
        input  req_valid_i, req_strength_i, req_len_i,
        input  msg_valid_i, msg_data_i, msg_strb_i, msg_last_i,
        input  sha3_msg_ready_i, sha3_absorbed_i,
        input  sha3_block_processed_i, sha3_state_valid_i,
        input  sha3_state_i, digest_ready_i,
        output req_ready_o, msg_ready_o,
        output sha3_msg_valid_o, sha3_msg_data_o, sha3_msg_strb_o,
        output sha3_strength_o, sha3_start_o, sha3_process_o,
        output sha3_run_o, sha3_done_o,
        output digest_valid_o, digest_data_o, digest_last_o,
        output busy_o, error_o
    );

    modport master (
        output req_valid_i, req_strength_i, req_len_i,
        output msg_valid_i, msg_data_i, msg_strb_i, msg_last_i,
        output sha3_msg_ready_i, sha3_absorbed_i,
        output sha3_block_processed_i, sha3_state_valid_i,
        output sha3_state_i, digest_ready_i,
        input  req_ready_o, msg_ready_o,
        input  sha3_msg_valid_o, sha3_msg_data_o, sha3_msg_strb_o,
        input  sha3_strength_o, sha3_start_o, sha3_process_o,
        input  sha3_run_o, sha3_done_o,
        input  digest_valid_o, digest_data_o, digest_last_o,
        input  busy_o, error_o
    );
endinterface

// File: rtl/sha3_app_seq.sv
// Sequencer turning one hash request into start/process/run/done pulses
// for the SHA3 core, forwarding message beats and streaming the digest.
module sha3_app_seq #(
    parameter int StateW = 1600,
    parameter int LenW   = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    sha3_app_seq_if.slave bus
);
    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StStart   = 4'd1,
        StAbsorb  = 4'd2,
        StProcess = 4'd3,
        StWaitAbs = 4'd4,
        StSqueeze = 4'd5,
        StRun     = 4'd6,
        StRunWait = 4'd7,
        StDone    = 4'd8
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      strength_q, strength_d;
    logic [LenW-1:0] remaining_q, remaining_d;
    logic [4:0]      idx_q, idx_d;
    logic            vld_q, vld_d;
    logic [4:0]      rate;
    logic            dig_hs;

    // Rate in 64-bit words for each Keccak strength.
    always_comb begin
        unique case (strength_q)
            3'd0:    rate = 5'd21;
            3'd1:    rate = 5'd18;
            3'd2:    rate = 5'd17;
            3'd3:    rate = 5'd13;
            default: rate = 5'd9;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        strength_d  = strength_q;
        remaining_d = remaining_q;
        idx_d       = idx_q;
        vld_d       = 1'b0;
        dig_hs      = 1'b0;

        bus.req_ready_o      = 1'b0;
        bus.msg_ready_o      = 1'b0;
        bus.sha3_msg_valid_o = 1'b0;
        bus.sha3_msg_data_o  = '0;
        bus.sha3_msg_strb_o  = '0;
        bus.sha3_start_o     = 1'b0;
        bus.sha3_process_o   = 1'b0;
        bus.sha3_run_o       = 1'b0;
        bus.sha3_done_o      = 1'b0;
        bus.digest_valid_o   = 1'b0;
        bus.digest_data_o    = '0;
        bus.digest_last_o    = 1'b0;
        bus.error_o          = 1'b0;

        unique case (state_q)
            StIdle: begin
                bus.req_ready_o = 1'b1;
                if (bus.req_valid_i) begin
                    if (bus.req_strength_i <= 3'd4) begin
                        strength_d  = bus.req_strength_i;
                        remaining_d = bus.req_len_i;
                        idx_d       = '0;
                        state_d     = StStart;
                    end else begin
                        bus.error_o = 1'b1;
                    end
                end
            end
            StStart: begin
                bus.sha3_start_o = 1'b1;
                state_d          = StAbsorb;
            end
            StAbsorb: begin
                bus.sha3_msg_valid_o = bus.msg_valid_i;
                bus.sha3_msg_data_o  = bus.msg_data_i;
                bus.sha3_msg_strb_o  = bus.msg_strb_i;
                bus.msg_ready_o      = bus.sha3_msg_ready_i;
                if (bus.msg_valid_i && bus.sha3_msg_ready_i &&
                    bus.msg_last_i) begin
                    state_d = StProcess;
                end
            end
            StProcess: begin
                bus.sha3_process_o = 1'b1;
                state_d            = StWaitAbs;
            end
            StWaitAbs: begin
                if (bus.sha3_absorbed_i) begin
                    idx_d   = '0;
                    state_d = (remaining_q == '0) ? StDone : StSqueeze;
                end
            end
            StSqueeze: begin
                bus.digest_valid_o = bus.sha3_state_valid_i;
                bus.digest_data_o  = bus.sha3_state_i[{idx_q, 6'd0} +: 64];
                bus.digest_last_o  = (remaining_q == LenW'(1));
                dig_hs = bus.sha3_state_valid_i && bus.digest_ready_i;
                // Track an offered-but-untaken word so a withdrawn valid is flagged.
                vld_d  = bus.sha3_state_valid_i && !dig_hs;
                if ((vld_q && !bus.sha3_state_valid_i) ||
                    bus.sha3_block_processed_i) begin
                    bus.error_o = 1'b1;
                end
                if (dig_hs) begin
                    remaining_d = remaining_q - LenW'(1);
                    idx_d       = idx_q + 5'd1;
                    if (remaining_q == LenW'(1)) begin
                        state_d = StDone;
                    end else if (idx_q + 5'd1 == rate) begin
                        idx_d   = '0;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                bus.sha3_run_o = 1'b1;
                state_d        = StRunWait;
            end
            StRunWait: begin
                if (bus.sha3_block_processed_i) begin
                    state_d = StSqueeze;
                end
            end
            StDone: begin
                bus.sha3_done_o = 1'b1;
                state_d         = StIdle;
            end
            default: begin
                bus.error_o = 1'b1;
                state_d     = StIdle;
            end
        endcase
    end

    assign bus.sha3_strength_o = strength_q;
    assign bus.busy_o          = (state_q != StIdle);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            strength_q  <= '0;
            remaining_q <= '0;
            idx_q       <= '0;
            vld_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            strength_q  <= strength_d;
            remaining_q <= remaining_d;
            idx_q       <= idx_d;
            vld_q       <= vld_d;
        end
    end
endmodule

// File: tb/tb_sha3_app_seq.sv
// Randomised bench: behavioural SHA3 core stand-in plus a digest model
// built from the captured block states and the strength rate table.
module tb_sha3_app_seq;
    localparam int StateW = 1600;
    localparam int LenW   = 16;
    localparam int Rate [5] = '{21, 18, 17, 13, 9};

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    sha3_app_seq_if #(.StateW(StateW), .LenW(LenW)) bus ();

    sha3_app_seq #(.StateW(StateW), .LenW(LenW)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    logic [72:0]       msg_q[$];
    logic [StateW-1:0] blocks[$];
    logic [63:0]       got_q[$];
    bit                last_q[$];
    logic [StateW-1:0] st;

    bit bp, known;
    int c_mode, c_cnt;
    bit ev_start, ev_proc, ev_run, ev_done, ev_acc;
    int acc_cyc, start_cyc, proc_cyc, abs_cyc, done_cyc;
    int first_beat_cyc, last_beat_cyc, last_dig_cyc;
    int n_start, n_run, n_done, n_beat, n_dvalid, errs, viol;
    bit done_seen, abs_win, stall_prev, rdy_f2, busy_at_done;
    logic [63:0] prev_data;
    logic [2:0]  str_seen;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [14:0] outs();
        return {bus.req_ready_o, bus.msg_ready_o, bus.sha3_msg_valid_o,
                bus.sha3_start_o, bus.sha3_process_o, bus.sha3_run_o,
                bus.sha3_done_o, bus.digest_valid_o, bus.digest_last_o,
                bus.busy_o, bus.error_o, |bus.digest_data_o,
                |bus.sha3_msg_data_o, |bus.sha3_msg_strb_o,
                |bus.sha3_strength_o};
    endfunction

    task automatic new_state();
        for (int i = 0; i < StateW / 32; i++) st[32*i +: 32] = $urandom;
        // Known SHA3-256("") digest for the empty-message case.
        if (known && blocks.size() == 0)
            st[255:0] = {64'h4a43f8804b0ad882, 64'hfa493be44dff80f5,
                         64'h62d661a05647c151, 64'h66d71ebff8c6ffa7};
        blocks.push_back(st);
        bus.sha3_state_i = st;
    endtask

    task automatic clr();
        got_q.delete(); last_q.delete(); blocks.delete(); msg_q.delete();
        acc_cyc = -1; start_cyc = -100; proc_cyc = -100; abs_cyc = -100;
        done_cyc = -100; first_beat_cyc = -100; last_beat_cyc = -100;
        last_dig_cyc = -100;
        n_start = 0; n_run = 0; n_done = 0; n_beat = 0; n_dvalid = 0;
        errs = 0; viol = 0;
        done_seen = 0; abs_win = 0; stall_prev = 0; rdy_f2 = 0;
        busy_at_done = 0; c_mode = 0;
    endtask

    task automatic observe();
        cyc++;
        ev_start = 0; ev_proc = 0; ev_run = 0; ev_done = 0; ev_acc = 0;
        if (bus.error_o) errs++;
        if (abs_win) begin
            if (bus.msg_ready_o !== bus.sha3_msg_ready_i ||
                bus.sha3_msg_valid_o !== bus.msg_valid_i) viol++;
        end else if (bus.msg_ready_o || bus.sha3_msg_valid_o) viol++;
        if (bus.req_valid_i && bus.req_ready_o) begin
            ev_acc = 1; acc_cyc = cyc;
        end
        if (bus.msg_valid_i && bus.msg_ready_o && msg_q.size() > 0) begin
            chk("msg_data", bus.sha3_msg_data_o, msg_q[0][63:0]);
            chk("msg_strb", 64'(bus.sha3_msg_strb_o), 64'(msg_q[0][71:64]));
            n_beat++;
            if (n_beat == 1) first_beat_cyc = cyc;
            if (msg_q[0][72]) begin
                last_beat_cyc = cyc; abs_win = 0;
            end
            void'(msg_q.pop_front());
        end
        if (bus.sha3_start_o) begin
            n_start++; start_cyc = cyc; ev_start = 1;
            str_seen = bus.sha3_strength_o;
        end
        if (bus.sha3_process_o) begin
            proc_cyc = cyc; ev_proc = 1;
        end
        if (bus.sha3_absorbed_i) abs_cyc = cyc;
        if (bus.sha3_run_o) begin
            n_run++; ev_run = 1;
            chk("run_lat", 64'(cyc - last_dig_cyc), 64'd1);
        end
        if (bus.sha3_done_o) begin
            n_done++; done_cyc = cyc; done_seen = 1; ev_done = 1;
            busy_at_done = bus.busy_o;
        end
        if (done_seen && cyc == done_cyc + 1) rdy_f2 = bus.req_ready_o;
        if (bus.digest_valid_o) n_dvalid++;
        if (stall_prev) begin
            chk("stall_vld", 64'(bus.digest_valid_o), 64'd1);
            chk("stall_data", bus.digest_data_o, prev_data);
        end
        if (bus.digest_valid_o && bus.digest_ready_i) begin
            got_q.push_back(bus.digest_data_o);
            last_q.push_back(bus.digest_last_o);
            last_dig_cyc = cyc;
        end
        stall_prev = bus.digest_valid_o && !bus.digest_ready_i;
        prev_data  = bus.digest_data_o;
    endtask

    task automatic update();
        if (ev_acc) bus.req_valid_i = 1'b0;
        bus.msg_valid_i = (msg_q.size() > 0);
        if (msg_q.size() > 0)
            {bus.msg_last_i, bus.msg_strb_i, bus.msg_data_i} = msg_q[0];
        bus.digest_ready_i   = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.sha3_msg_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.sha3_absorbed_i        = 1'b0;
        bus.sha3_block_processed_i = 1'b0;
        if (ev_start) abs_win = 1;
        // Core stand-in: 0 idle, 1 absorbing, 2 absorbing tail, 3 squeezable, 4 permuting.
        if (ev_done) begin
            c_mode = 0; bus.sha3_state_valid_i = 1'b0;
        end else if (ev_run) begin
            c_mode = 4; c_cnt = $urandom_range(1, 4);
            bus.sha3_state_valid_i = 1'b0;
        end else if (ev_proc) begin
            c_mode = 2; c_cnt = $urandom_range(1, 4);
        end else if (ev_start) begin
            c_mode = 1;
        end else if (c_mode == 2 || c_mode == 4) begin
            c_cnt--;
            if (c_cnt == 0) begin
                new_state();
                bus.sha3_state_valid_i = 1'b1;
                if (c_mode == 2) bus.sha3_absorbed_i = 1'b1;
                else bus.sha3_block_processed_i = 1'b1;
                c_mode = 3;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk_i);
        observe();
        @(posedge clk_i);
        #1;
        update();
    endtask

    task automatic run_req(input int str, input int len, input int nbeats,
                           input bit bpi, input bit kn, input int abort_at);
        logic [StateW-1:0] blk;
        logic [63:0] exp_w;
        int r;
        clr();
        bp = bpi; known = kn;
        for (int b = 0; b < nbeats; b++)
            msg_q.push_back({(b == nbeats - 1),
                             kn ? 8'h00 : 8'($urandom_range(1, 255)),
                             $urandom, $urandom});
        bus.req_valid_i    = 1'b1;
        bus.req_strength_i = 3'(str);
        bus.req_len_i      = LenW'(len);
        for (int i = 0; i < 3000; i++) begin
            cycle();
            if (abort_at > 0 && got_q.size() >= abort_at) return;
            if (done_seen && cyc >= done_cyc + 1) break;
        end
        chk("timeout", 64'(done_seen), 64'd1);
        if (!done_seen) return;
        r = Rate[str];
        chk("strength", 64'(str_seen), 64'(str));
        chk("n_start", 64'(n_start), 64'd1);
        chk("start_lat", 64'(start_cyc - acc_cyc), 64'd1);
        chk("beat_lat", 64'(first_beat_cyc - acc_cyc >= 2), 64'd1);
        chk("n_beat", 64'(n_beat), 64'(nbeats));
        chk("proc_lat", 64'(proc_cyc - last_beat_cyc), 64'd1);
        chk("n_words", 64'(got_q.size()), 64'(len));
        for (int k = 0; k < got_q.size() && k < len; k++) begin
            blk   = (k / r < blocks.size()) ? blocks[k / r] : '0;
            exp_w = blk[64 * (k % r) +: 64];
            chk($sformatf("word%0d", k), got_q[k], exp_w);
            chk($sformatf("last%0d", k), 64'(last_q[k]), 64'(k == len - 1));
        end
        if (len == 0) chk("no_dvalid", 64'(n_dvalid), 64'd0);
        chk("n_run", 64'(n_run), 64'(len == 0 ? 0 : (len - 1) / r));
        chk("n_done", 64'(n_done), 64'd1);
        chk("done_lat", 64'(done_cyc - (len > 0 ? last_dig_cyc : abs_cyc)),
            64'd1);
        chk("busy_done", 64'(busy_at_done), 64'd1);
        chk("rdy_f2", 64'(rdy_f2), 64'd1);
        chk("msg_gate", 64'(viol), 64'd0);
        chk("errors", 64'(errs), 64'd0);
    endtask

    initial begin
        bus.req_valid_i = 0; bus.req_strength_i = 0; bus.req_len_i = 0;
        bus.msg_valid_i = 0; bus.msg_data_i = 0; bus.msg_strb_i = 0;
        bus.msg_last_i = 0; bus.sha3_msg_ready_i = 0;
        bus.sha3_absorbed_i = 0; bus.sha3_block_processed_i = 0;
        bus.sha3_state_valid_i = 0; bus.sha3_state_i = '0;
        bus.digest_ready_i = 0;
        clr();
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_outs", 64'(outs()), 64'h4000);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        chk("idle_outs", 64'(outs()), 64'h4000);

        // SHA3-256 of the empty message.
        run_req(2, 4, 1, 0, 1, 0);
        chk("sha256_w0", got_q.size() > 0 ? got_q[0] : 64'h0,
            64'h66d71ebff8c6ffa7);
        chk("sha256_w3", got_q.size() > 3 ? got_q[3] : 64'h0,
            64'h4a43f8804b0ad882);

        run_req(0, 25, 5, 0, 0, 0);
        run_req(4, 0, 3, 0, 0, 0);
        run_req(3, 30, 6, 1, 0, 0);

        // Illegal strength is accepted and dropped.
        clr();
        bus.req_valid_i = 1'b1; bus.req_strength_i = 3'd5;
        bus.req_len_i = LenW'(3);
        repeat (4) cycle();
        chk("ill_acc", 64'(acc_cyc > 0), 64'd1);
        chk("ill_err", 64'(errs), 64'd1);
        chk("ill_start", 64'(n_start), 64'd0);
        chk("ill_busy", 64'(bus.busy_o), 64'd0);
        run_req(1, 3, 2, 0, 0, 0);

        // Reset in the middle of squeezing.
        run_req(2, 8, 2, 0, 0, 3);
        rst_ni = 1'b0;
        #1;
        chk("rst_async", 64'(outs()), 64'h4000);
        c_mode = 0; msg_q.delete();
        bus.req_valid_i = 0; bus.msg_valid_i = 0;
        bus.sha3_state_valid_i = 0; bus.sha3_absorbed_i = 0;
        bus.sha3_block_processed_i = 0;
        @(posedge clk_i);
        #1;
        chk("rst_edge", 64'(outs()), 64'h4000);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        run_req(1, 7, 4, 1, 0, 0);

        for (int t = 0; t < 4; t++)
            run_req($urandom_range(0, 4), $urandom_range(0, 40),
                    $urandom_range(1, 6), 1'($urandom_range(0, 1)), 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
